// File: rtl/locker_access_arbiter_if.sv
// rtl/locker_access_arbiter_if.sv - keypad and locker signal bundle for the access arbiter
interface locker_access_arbiter_if #(
    parameter int NUM_PADS = 2
);
    logic [NUM_PADS-1:0]   pad_req;
    logic [NUM_PADS-1:0]   pad_submit;
    logic [4*NUM_PADS-1:0] pad_digit;
    logic [NUM_PADS-1:0]   pad_grant;
    logic                  lk_submit;
    logic [3:0]            lk_digit;
    logic                  lk_reset;
    logic                  lk_unlocked;
    logic                  lk_locked;
    logic                  busy;
    logic                  lockout;
    logic                  session_done;
    logic                  session_pass;

    modport slave (
        input  pad_req, pad_submit, pad_digit, lk_unlocked, lk_locked,
        output pad_grant, lk_submit, lk_digit, lk_reset, busy, lockout,
               session_done, session_pass
    );

    modport master (
        output pad_req, pad_submit, pad_digit, lk_unlocked, lk_locked,
        input  pad_grant, lk_submit, lk_digit, lk_reset, busy, lockout,
               session_done, session_pass
    );
endinterface

// File: rtl/locker_access_arbiter.sv
// rtl/locker_access_arbiter.sv - round-robin keypad arbiter and session sequencer for one shared locker
module locker_access_arbiter #(
    parameter int NUM_PADS       = 2,
    parameter int CODE_LEN       = 4,
    parameter int IDLE_TIMEOUT   = 50,
    parameter int RESULT_WAIT    = 2,
    parameter int HOLD_CYCLES    = 20,
    parameter int LOCKOUT_CYCLES = 100
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    locker_access_arbiter_if.slave bus
);
    localparam int PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int CW = $clog2(CODE_LEN) + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
    localparam int RW = $clog2(RESULT_WAIT) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_FLUSH, S_WAIT, S_HOLD, S_LOCKOUT, S_RELOCK
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [NUM_PADS-1:0] grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic [RW-1:0]       wait_q, wait_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [LW-1:0]       lock_q, lock_d;
    logic                gap_q, gap_d;
    logic [NUM_PADS-1:0] sub_q;
    logic                lk_submit_q, lk_submit_d;
    logic [3:0]          lk_digit_q, lk_digit_d;
    logic                lk_reset_q, lk_reset_d;
    logic                busy_q, busy_d;
    logic                lockout_q, lockout_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                pick_found;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       cand;
    logic [NUM_PADS-1:0] sub_edge;
    logic                g_edge;
    logic                g_req;
    logic [3:0]          g_digit;
    logic                idle_expired;

    assign sub_edge     = bus.pad_submit & ~sub_q;
    assign g_edge       = sub_edge[gidx_q];
    assign g_req        = bus.pad_req[gidx_q];
    assign g_digit      = bus.pad_digit[{gidx_q, 2'b00} +: 4];
    assign idle_expired = (idle_q >= TW'(IDLE_TIMEOUT - 1));

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            cand = PW'((int'(rr_q) + k) % NUM_PADS);
            if (!pick_found && bus.pad_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        wait_d      = wait_q;
        hold_d      = hold_q;
        lock_d      = lock_q;
        gap_d       = gap_q;
        lk_submit_d = 1'b0;
        lk_digit_d  = lk_digit_q;
        lk_reset_d  = 1'b0;
        lockout_d   = lockout_q;
        done_d      = 1'b0;
        pass_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_COLLECT;
                    gidx_d  = pick_idx;
                    grant_d = NUM_PADS'(1) << pick_idx;
                    rr_d    = (pick_idx == PW'(NUM_PADS - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end
            S_COLLECT: begin
                // A digit beats both a request drop and an expiring idle timer.
                if (g_edge) begin
                    lk_submit_d = 1'b1;
                    lk_digit_d  = g_digit;
                    cnt_d       = cnt_q + 1'b1;
                    idle_d      = '0;
                    if (cnt_q == CW'(CODE_LEN - 1)) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end
                end else if (!g_req || idle_expired) begin
                    if (cnt_q != '0) begin
                        state_d = S_FLUSH;
                        gap_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else if (idle_q != TW'(IDLE_TIMEOUT)) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_FLUSH: begin
                gap_d = ~gap_q;
                if (!gap_q) begin
                    lk_submit_d = 1'b1;
                    lk_digit_d  = 4'hF;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CW'(CODE_LEN - 1)) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == RW'(RESULT_WAIT)) begin
                    done_d  = 1'b1;
                    grant_d = '0;
                    if (bus.lk_locked) begin
                        state_d   = S_LOCKOUT;
                        lockout_d = 1'b1;
                        lock_d    = '0;
                    end else if (bus.lk_unlocked) begin
                        state_d = S_HOLD;
                        pass_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d    = S_RELOCK;
                    lk_reset_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (lock_q == LW'(LOCKOUT_CYCLES - 1)) begin
                    state_d    = S_RELOCK;
                    lk_reset_d = 1'b1;
                    lockout_d  = 1'b0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            S_RELOCK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            wait_q      <= '0;
            hold_q      <= '0;
            lock_q      <= '0;
            gap_q       <= 1'b0;
            sub_q       <= '0;
            lk_submit_q <= 1'b0;
            lk_digit_q  <= 4'h0;
            lk_reset_q  <= 1'b0;
            busy_q      <= 1'b0;
            lockout_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            lock_q      <= lock_d;
            gap_q       <= gap_d;
            sub_q       <= bus.pad_submit;
            lk_submit_q <= lk_submit_d;
            lk_digit_q  <= lk_digit_d;
            lk_reset_q  <= lk_reset_d;
            busy_q      <= busy_d;
            lockout_q   <= lockout_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.pad_grant    = grant_q;
    assign bus.lk_submit    = lk_submit_q;
    assign bus.lk_digit     = lk_digit_q;
    assign bus.lk_reset     = lk_reset_q;
    assign bus.busy         = busy_q;
    assign bus.lockout      = lockout_q;
    assign bus.session_done = done_q;
    assign bus.session_pass = pass_q;
endmodule

// File: tb/tb_locker_access_arbiter.sv
// tb/tb_locker_access_arbiter.sv - randomized scoreboard bench for locker_access_arbiter
module tb_locker_access_arbiter;
    localparam int NP = 2;
    localparam int CL = 4;
    localparam int IT = 50;
    localparam int RWAIT = 2;
    localparam int HC = 20;
    localparam int LC = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    locker_access_arbiter_if #(.NUM_PADS(NP)) bus ();

    locker_access_arbiter #(
        .NUM_PADS(NP), .CODE_LEN(CL), .IDLE_TIMEOUT(IT),
        .RESULT_WAIT(RWAIT), .HOLD_CYCLES(HC), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cyc = 0;
    logic [NP-1:0] prev_grant;
    logic prev_sub;

    logic [3:0] exp_digit[$];
    int exp_grant[$];
    bit exp_pass[$];
    bit exp_lock[$];
    int exp_rdelay[$];

    int rr_m = 0;
    int fails_m = 0;
    logic [3:0] secret [CL] = '{4'd1, 4'd2, 4'd3, 4'd4};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Locker stand-in: three consecutive wrong codes lock it, lk_reset clears it.
    logic [11:0] lk_sr;
    int lk_cnt;
    int lk_fails;
    always @(posedge clk or posedge rst) begin
        if (rst || bus.lk_reset) begin
            lk_sr <= '0;
            lk_cnt <= 0;
            lk_fails <= 0;
            bus.lk_unlocked <= 1'b0;
            bus.lk_locked <= 1'b0;
        end else if (bus.lk_submit) begin
            if (lk_cnt == CL - 1) begin
                lk_cnt <= 0;
                if ({lk_sr, bus.lk_digit} == 16'h1234) bus.lk_unlocked <= 1'b1;
                else begin
                    lk_fails <= lk_fails + 1;
                    if (lk_fails == 2) bus.lk_locked <= 1'b1;
                end
            end else begin
                lk_sr <= {lk_sr[7:0], bus.lk_digit};
                lk_cnt <= lk_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_grant = '0;
            prev_sub = 1'b0;
        end else begin
            if (bus.pad_grant != '0 && prev_grant == '0) begin
                if (exp_grant.size() == 0) check("unexpected_grant", int'(bus.pad_grant), 0);
                else check("grant", int'(bus.pad_grant), 1 << exp_grant.pop_front());
            end
            if (bus.lk_submit) begin
                check("submit_gap", int'(prev_sub), 0);
                check("grant_during_submit", int'(bus.pad_grant != '0), 1);
                if (exp_digit.size() == 0) check("unexpected_submit", 1, 0);
                else check("lk_digit", int'(bus.lk_digit), int'(exp_digit.pop_front()));
            end
            if (bus.lockout) check("grant_in_lockout", int'(bus.pad_grant), 0);
            if (bus.session_done) begin
                if (exp_pass.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    bit ep, el;
                    ep = exp_pass.pop_front();
                    el = exp_lock.pop_front();
                    check("session_pass", int'(bus.session_pass), int'(ep));
                    check("lockout_at_done", int'(bus.lockout), int'(el));
                    check("grant_clear_at_done", int'(bus.pad_grant), 0);
                    done_cyc = cyc;
                end
            end
            if (bus.lk_reset) begin
                if (exp_rdelay.size() == 0) check("unexpected_lk_reset", 1, 0);
                else check("relock_delay", cyc - done_cyc, exp_rdelay.pop_front());
            end
            prev_grant = bus.pad_grant;
            prev_sub = bus.lk_submit;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, int'(bus.pad_grant), 0);
        check({tag, "_lk_submit"}, int'(bus.lk_submit), 0);
        check({tag, "_lk_digit"}, int'(bus.lk_digit), 0);
        check({tag, "_lk_reset"}, int'(bus.lk_reset), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_lockout"}, int'(bus.lockout), 0);
        check({tag, "_done"}, int'(bus.session_done), 0);
        check({tag, "_pass"}, int'(bus.session_pass), 0);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.pad_grant != '0) ok = 1'b1;
        end
        if (!ok) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.session_done) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic raise_digit(input int p, input logic [3:0] d, input bit drop_req);
        bus.pad_digit[4*p +: 4] = d;
        bus.pad_submit[p] = 1'b1;
        if (drop_req) bus.pad_req[p] = 1'b0;
        exp_digit.push_back(d);
        @(negedge clk);
        check("submit_latency", int'(bus.lk_submit), 1);
        bus.pad_submit[p] = 1'b0;
    endtask

    // mode 0: full code, 1: partial then silent, 2: partial then request dropped
    task automatic run_session(input logic [NP-1:0] reqs, input int mode, input int ndig, input bit correct);
        int g, n, lat;
        bit ok, pass, lock;
        logic [3:0] code [CL];
        g = -1;
        for (int k = 0; k < NP; k++)
            if (g < 0 && reqs[(rr_m + k) % NP]) g = (rr_m + k) % NP;
        rr_m = (g + 1) % NP;
        exp_grant.push_back(g);
        bus.pad_req = reqs;
        wait_grant(ok);
        bus.pad_req = '0;
        if (!ok) return;
        if (mode == 2 && ndig == 0) begin
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk);
                if (!bus.busy) ok = 1'b1;
            end
            check("empty_abort_idle", int'(ok), 1);
            return;
        end
        bus.pad_req[g] = 1'b1;
        n = (mode == 0) ? CL : ndig;
        for (int k = 0; k < CL; k++) code[k] = 4'hF;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 3)) begin
                for (int p = 0; p < NP; p++)
                    if (p != g) bus.pad_submit[p] = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            for (int p = 0; p < NP; p++)
                if (p != g) bus.pad_submit[p] = 1'b0;
            code[k] = correct ? secret[k] : 4'($urandom_range(0, 9));
            raise_digit(g, code[k], mode == 0 && k == n - 1);
        end
        for (int k = n; k < CL; k++) exp_digit.push_back(4'hF);
        pass = 1'b1;
        for (int k = 0; k < CL; k++)
            if (code[k] != secret[k]) pass = 1'b0;
        lock = 1'b0;
        if (pass) fails_m = 0;
        else begin
            fails_m++;
            if (fails_m == 3) begin
                lock = 1'b1;
                fails_m = 0;
            end
        end
        exp_pass.push_back(pass);
        exp_lock.push_back(lock);
        if (pass) exp_rdelay.push_back(HC);
        else if (lock) exp_rdelay.push_back(LC);
        if (mode == 1) begin
            lat = 0;
            for (int i = 1; i <= 200 && lat == 0; i++) begin
                @(negedge clk);
                if (bus.lk_submit) lat = i;
            end
            check("timeout_latency", lat, IT + 1);
        end else if (mode == 2) begin
            @(negedge clk);
            bus.pad_req[g] = 1'b0;
        end
        wait_done(ok);
        bus.pad_req = '0;
    endtask

    initial begin
        bit ok;
        int mode, nd;
        rst = 1'b1;
        bus.pad_req = '0;
        bus.pad_submit = '0;
        bus.pad_digit = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        run_session(2'b11, 0, CL, 1'b1);
        run_session(2'b11, 0, CL, 1'b0);
        run_session(2'b11, 0, CL, 1'b0);
        run_session(2'b11, 0, CL, 1'b0);
        run_session(2'b10, 1, 2, 1'b0);

        for (int s = 0; s < 25; s++) begin
            mode = $urandom_range(0, 2);
            nd = (mode == 1) ? $urandom_range(1, CL - 1) : $urandom_range(0, CL - 1);
            run_session(2'($urandom_range(1, 3)), mode, nd, $urandom_range(0, 2) == 0);
        end

        exp_grant.push_back(0);
        rr_m = 1;
        bus.pad_req = 2'b01;
        wait_grant(ok);
        raise_digit(0, 4'd5, 1'b0);
        @(negedge clk);
        raise_digit(0, 4'd6, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_digit.delete();
        exp_grant.delete();
        exp_pass.delete();
        exp_lock.delete();
        exp_rdelay.delete();
        rr_m = 0;
        fails_m = 0;
        #1;
        check_outputs_zero("async_reset");
        bus.pad_req = '0;
        @(negedge clk);
        rst = 1'b0;
        run_session(2'b11, 2, 0, 1'b0);
        run_session(2'b11, 0, CL, 1'b1);

        repeat (40) @(negedge clk);
        check("left_digits", exp_digit.size(), 0);
        check("left_grants", exp_grant.size(), 0);
        check("left_sessions", exp_pass.size(), 0);
        check("left_relocks", exp_rdelay.size(), 0);
        check("final_busy", int'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/locker_access_arbiter.md
Name: locker_access_arbiter

Overview:
- Shares one digital_locker between NUM_PADS keypads and sequences each session.
- Grants the locker to one keypad at a time (round-robin), forwards that keypad's digits, and flushes abandoned partial codes.
- Evaluates the locker result, then drives the locker's reset to relock after a successful unlock or to release a lockout.
- Sits between keypad front-ends and the locker.

Parameters:
- NUM_PADS, 2, number of requesting keypads (2..4).
- CODE_LEN, 4, digits per code; must match the locker.
- IDLE_TIMEOUT, 50, cycles without a digit from the granted pad before it is aborted.
- RESULT_WAIT, 2, cycles from the last forwarded lk_submit until the locker status is sampled.
- HOLD_CYCLES, 20, cycles the locker is held unlocked before relock.
- LOCKOUT_CYCLES, 100, cycles spent in lockout before the locker is reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pad_req  in  NUM_PADS  per-pad access request (level).
- pad_submit  in  NUM_PADS  per-pad digit strobe (level; rising edge = one digit).
- pad_digit  in  4*NUM_PADS  per-pad digit; pad i uses bits [4i+3:4i].
- pad_grant  out  NUM_PADS  one-hot grant; all zero when no session.
- lk_submit  out  1  to locker submit; one-cycle pulse.
- lk_digit  out  4  to locker digit_in.
- lk_reset  out  1  to locker reset; one-cycle pulse.
- lk_unlocked  in  1  from locker.
- lk_locked  in  1  from locker.
- busy  out  1  high in every state except IDLE.
- lockout  out  1  high in LOCKOUT.
- session_done  out  1  one-cycle pulse at the end of each evaluated session.
- session_pass  out  1  valid with session_done; 1 = unlocked.

Behaviour:
- Reset: state IDLE; pad_grant=0, lk_submit=0, lk_digit=0, lk_reset=0, busy=0, lockout=0, session_done=0, session_pass=0; RR pointer=0; digit count=0; submit-edge history registers=0.
- All outputs are registered.
- IDLE:
  - When any pad_req is high, grant the first requester at or after the RR pointer (wrapping), load pad_grant, go to COLLECT.
  - The RR pointer then becomes granted index+1 mod NUM_PADS.
- COLLECT:
  - A rising edge on pad_submit of the granted pad is seen at edge t. At t+1, lk_submit=1 with lk_digit = that pad's digit; count increments.
  - Submit edges from non-granted pads are ignored.
  - When count reaches CODE_LEN, go to WAIT_RESULT.
  - Granted pad_req dropping, or IDLE_TIMEOUT cycles with no digit, with count>0: go to FLUSH.
  - Same conditions with count==0: go to IDLE with no locker traffic.
- FLUSH:
  - Inject the remaining CODE_LEN-count digits as 4'hF.
  - Each injected digit is a one-cycle lk_submit pulse followed by one low cycle.
  - Then go to WAIT_RESULT. A flushed session consumes a locker attempt by design.
- WAIT_RESULT:
  - Count RESULT_WAIT cycles after the final lk_submit pulse, then sample lk_locked and lk_unlocked.
  - Priority: lk_locked first, then lk_unlocked, then fail.
  - In all cases pulse session_done with session_pass = (outcome is UNLOCK_HOLD).
  - lk_locked -> LOCKOUT; lk_unlocked -> UNLOCK_HOLD; otherwise -> IDLE.
- UNLOCK_HOLD: wait HOLD_CYCLES, then go to RELOCK.
- LOCKOUT:
  - lockout=1 throughout; pad requests are not granted.
  - After LOCKOUT_CYCLES go to RELOCK.
- RELOCK: lk_reset=1 for exactly one cycle, then IDLE.
- pad_grant stays asserted through COLLECT, FLUSH and WAIT_RESULT. It clears on entry to IDLE, UNLOCK_HOLD or LOCKOUT.
- Counters:
  - Each counter's width is clog2 of its parameter + 1.
  - Counters saturate and never wrap.
  - Digit count is cleared on every grant.
- Simultaneous events:
  - A pad_submit edge in the same cycle as a timeout: the digit wins and the timeout counter reloads.
  - A req drop in the same cycle as the final digit: the digit wins and the session goes to WAIT_RESULT.
- Reset mid-session: everything returns to reset values immediately. No lk_reset pulse is generated; the locker shares the system reset.

Test Plan:
- Pad0 requests and enters 1,2,3,4 -> pad_grant=01; four lk_submit pulses carrying 1,2,3,4, each one cycle after the pad edge; session_done with session_pass=1; after 20 cycles one lk_reset pulse; back to IDLE.
- Pad0 and pad1 request in the same cycle from reset -> pad0 granted first; after its failed code 0,0,0,0 (session_pass=0), pad1 is granted; the next simultaneous request grants pad0 (round-robin).
- Pad1 enters 9,9 then goes silent -> after 50 idle cycles, FLUSH emits two lk_digit=F pulses with gaps; session_done pulses with session_pass=0.
- Three wrong codes (0000, 9999, 8888) -> third session ends with lockout=1; requests are ignored for 100 cycles; then one lk_reset pulse; lockout=0; next request is granted.
- Pad1 toggles pad_submit while pad0 holds the grant -> no lk_submit from pad1; digit count unaffected.
- reset asserted during COLLECT after 2 digits -> all outputs 0 asynchronously; new request grants from the RR pointer=0.
